// File: rtl/jk_bank_arbiter.sv
// Bank of WIDTH JK flip-flops shared by NREQ requesters through a round-robin
// arbiter; a granted requester may lock the bank for back-to-back commands.
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [2*NREQ-1:0]       jk,
  input  logic [WIDTH*NREQ-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic [IDW-1:0]          gnt_id,
  output logic                    locked,
  output logic [WIDTH-1:0]        q
);

  localparam logic [0:0]     ST_IDLE   = 1'b0;
  localparam logic [0:0]     ST_LOCKED = 1'b1;
  localparam logic [IDW:0]   NREQ_W    = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] bank_q, bank_d;

  logic             win_valid;
  logic [IDW-1:0]   win_id;
  logic [IDW:0]     cand;
  logic             sel_valid;
  logic [IDW-1:0]   sel_id;
  logic [1:0]       jk_sel;
  logic [WIDTH-1:0] mask_sel;

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req[cand[IDW-1:0]]) begin
        win_valid = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (state_q == ST_LOCKED) begin
      sel_valid = req[owner_q];
      sel_id    = owner_q;
      if (!req[owner_q] || !lock[owner_q]) state_d = ST_IDLE;
    end else begin
      sel_valid = win_valid;
      sel_id    = win_id;
      if (win_valid && lock[win_id]) begin
        state_d = ST_LOCKED;
        owner_d = win_id;
      end
    end
  end

  always_comb begin
    jk_sel   = 2'b00;
    mask_sel = '0;
    gnt_d    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_id == IDW'(i)) begin
        jk_sel   = jk[2*i +: 2];
        mask_sel = mask[WIDTH*i +: WIDTH];
        gnt_d[i] = sel_valid;
      end
    end
  end

  // While locked, sel_id is the owner, so the pointer stays at owner+1.
  always_comb begin
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    if (sel_valid) begin
      ptr_d    = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
      gnt_id_d = sel_id;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic jk_next;
      always_comb begin
        case (jk_sel)
          2'b01:   jk_next = 1'b0;
          2'b10:   jk_next = 1'b1;
          2'b11:   jk_next = ~bank_q[gi];
          default: jk_next = bank_q[gi];
        endcase
      end
      assign bank_d[gi] = (sel_valid && mask_sel[gi]) ? jk_next : bank_q[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      bank_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      bank_q   <= bank_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign locked = (state_q == ST_LOCKED);
  assign q      = bank_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: reset, single commands, round-robin,
// lock/unlock, reset while locked and mask/no-op edge cases.
module tb_jk_bank_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [7:0]  jk;
  logic [31:0] mask;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        locked;
  logic [7:0]  q;

  int checks = 0;
  int errors = 0;

  jk_bank_arbiter #(.WIDTH(8), .NREQ(4), .IDW(2)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .lock   (lock),
    .jk     (jk),
    .mask   (mask),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .locked (locked),
    .q      (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [1:0] v, input logic [7:0] m);
    jk[2*i +: 2]   = v;
    mask[8*i +: 8] = m;
  endtask

  task automatic test_reset();
    req = 4'b0001; lock = 4'b0000;
    set_cmd(0, 2'b10, 8'hA5);
    step();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL rst_pre_q got %h expected %h", q, 8'hA5); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_pre_gnt got %b expected %b", gnt, 4'b0001); end
    req = 4'b0000;
    #3 reset_n = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_q got %h expected %h", q, 8'h00); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b expected %b", gnt, 4'b0000); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b expected %b", locked, 1'b0); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL rst_gnt_id got %0d expected %0d", gnt_id, 0); end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0001;
    set_cmd(0, 2'b10, 8'h0F);
    step();
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL single_set_q got %h expected %h", q, 8'h0F); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_set_gnt got %b expected %b", gnt, 4'b0001); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL single_set_id got %0d expected %0d", gnt_id, 0); end
    set_cmd(0, 2'b11, 8'hFF);
    step();
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL single_tog_q got %h expected %h", q, 8'hF0); end
    req = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt got %b expected %b", gnt, 4'b0000); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL single_idle_id got %0d expected %0d", gnt_id, 0); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    logic [1:0] exp_id  [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    // pointer sits at 1; a no-op grant to requester 3 brings it back to 0
    req = 4'b1000;
    set_cmd(3, 2'b00, 8'h00);
    step();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rr_pre_gnt got %b expected %b", gnt, 4'b1000); end
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL rr_pre_q got %h expected %h", q, 8'hF0); end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b11, 8'h01);
    for (int n = 0; n < 5; n++) begin
      step();
      checks++; if (gnt !== exp_gnt[n]) begin errors++; $display("FAIL rr_gnt[%0d] got %b expected %b", n, gnt, exp_gnt[n]); end
      checks++; if (gnt_id !== exp_id[n]) begin errors++; $display("FAIL rr_id[%0d] got %0d expected %0d", n, gnt_id, exp_id[n]); end
      checks++; if (q[0] !== ((n % 2) == 0)) begin errors++; $display("FAIL rr_q0[%0d] got %b expected %b", n, q[0], (n % 2) == 0); end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_lock();
    logic [7:0] exp_q [3];
    exp_q = '{8'h71, 8'hF1, 8'h71};
    req = 4'b0110; lock = 4'b0010;
    set_cmd(1, 2'b11, 8'h80);
    set_cmd(2, 2'b10, 8'h02);
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_gnt[%0d] got %b expected %b", n, gnt, 4'b0010); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked[%0d] got %b expected %b", n, locked, 1'b1); end
      checks++; if (q !== exp_q[n]) begin errors++; $display("FAIL lock_q[%0d] got %h expected %h", n, q, exp_q[n]); end
    end
    lock = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL unlock_final_gnt got %b expected %b", gnt, 4'b0010); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL unlock_locked got %b expected %b", locked, 1'b0); end
    checks++; if (q !== 8'hF1) begin errors++; $display("FAIL unlock_q got %h expected %h", q, 8'hF1); end
    req = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL unlock_next_gnt got %b expected %b", gnt, 4'b0100); end
    checks++; if (q !== 8'hF3) begin errors++; $display("FAIL unlock_next_q got %h expected %h", q, 8'hF3); end
    // owner drops req while locked: no grant, lock released
    req = 4'b0001; lock = 4'b0001;
    set_cmd(0, 2'b00, 8'h00);
    step();
    checks++; if (gnt !== 4'b0001 || locked !== 1'b1) begin errors++; $display("FAIL relock got gnt=%b locked=%b expected gnt=0001 locked=1", gnt, locked); end
    req = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0000 || locked !== 1'b0) begin errors++; $display("FAIL drop_req got gnt=%b locked=%b expected gnt=0000 locked=0", gnt, locked); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL drop_req_id got %0d expected %0d", gnt_id, 0); end
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL after_drop_gnt got %b expected %b", gnt, 4'b0100); end
    req = 4'b0000; lock = 4'b0000;
    step();
  endtask

  task automatic test_reset_locked();
    req = 4'b0001; lock = 4'b0001;
    set_cmd(0, 2'b00, 8'hFF);
    step();
    checks++; if (gnt !== 4'b0001 || locked !== 1'b1) begin errors++; $display("FAIL rl_lock got gnt=%b locked=%b expected gnt=0001 locked=1", gnt, locked); end
    req = 4'b1001;
    set_cmd(3, 2'b10, 8'h3C);
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rl_wait_gnt got %b expected %b", gnt, 4'b0001); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rl_rst_locked got %b expected %b", locked, 1'b0); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rl_rst_q got %h expected %h", q, 8'h00); end
    #1 reset_n = 1'b1;
    lock = 4'b0000;
    set_cmd(0, 2'b10, 8'hFF);
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rl_ptr0_gnt got %b expected %b", gnt, 4'b0001); end
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL rl_ptr0_q got %h expected %h", q, 8'hFF); end
    req = 4'b1000;
    step();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rl_gnt3 got %b expected %b", gnt, 4'b1000); end
    checks++; if (gnt_id !== 2'd3) begin errors++; $display("FAIL rl_id3 got %0d expected %0d", gnt_id, 3); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_mask_hold();
    req = 4'b0100;
    set_cmd(2, 2'b01, 8'h00);
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mask0_gnt got %b expected %b", gnt, 4'b0100); end
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL mask0_q got %h expected %h", q, 8'hFF); end
    req = 4'b0010;
    set_cmd(1, 2'b00, 8'hFF);
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL hold_gnt got %b expected %b", gnt, 4'b0010); end
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL hold_q got %h expected %h", q, 8'hFF); end
    req = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt got %b expected %b", gnt, 4'b0000); end
    checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL idle_id_hold got %0d expected %0d", gnt_id, 1); end
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0; lock = '0; jk = '0; mask = '0;
    repeat (2) @(posedge clock);
    #6 reset_n = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_reset_locked();
    test_mask_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
